// File: rtl/eight_data_decompress_unit_pkg.sv
// Shared definitions for the eight-word compress/decompress pair:
// tag encoding and the tag-to-byte-length mapping.
package eight_data_decompress_unit_pkg;

    localparam int NUM_UNITS = 8;
    localparam int TAG_BYTES = 2;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_ZERO = 2'b00;
    localparam tag_t TAG_B1   = 2'b01;
    localparam tag_t TAG_B2   = 2'b10;
    localparam tag_t TAG_RAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic [2:0] byteLen(input tag_t tag);
        case (tag)
            TAG_ZERO: byteLen = 3'd0;
            TAG_B1:   byteLen = 3'd1;
            TAG_B2:   byteLen = 3'd2;
            default:  byteLen = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/eight_data_decompress_unit_word_decoder.sv
// Expands one payload window into a full 32-bit word according to its tag.
module word_decoder
    import eight_data_decompress_unit_pkg::*;
(
    input  tag_t        tag,
    input  logic [31:0] window,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (tag)
            TAG_ZERO: word = '0;
            TAG_B1:   word = {{24{window[7]}}, window[7:0]};
            TAG_B2:   word = {{16{window[15]}}, window[15:0]};
            default:  word = window;
        endcase
    end

endmodule

// File: rtl/eight_data_decompress_unit.sv
// Unpacks one compressed block into eight words, one word per cycle, by
// consuming bytes from the bottom of a shift register.
module eight_data_decompress_unit
    import eight_data_decompress_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_WIDTH*8-1:0]   dataIn,
    input  logic [TAG_WIDTH*8-1:0]    tagIn,
    input  logic [LEN_WIDTH-1:0]      lenIn,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [DATA_WIDTH*8-1:0]   dataOut,
    output logic                      lenErr
);

    state_t                                  state, stateNext;
    logic [DATA_WIDTH*8-1:0]                 sr;
    logic [TAG_WIDTH*8-1:0]                  tr;
    logic [LEN_WIDTH-1:0]                    lr, sum, sumNext;
    logic [2:0]                              idx;
    logic [NUM_UNITS-2:0][DATA_WIDTH-1:0]    outBuf;
    tag_t                                    curTag;
    logic [2:0]                              curLen;
    logic [DATA_WIDTH-1:0]                   curWord;

    assign curTag  = tr[idx*TAG_WIDTH +: TAG_WIDTH];
    assign curLen  = byteLen(curTag);
    assign sumNext = sum + LEN_WIDTH'(curLen);

    word_decoder uDec (
        .tag    (curTag),
        .window (sr[DATA_WIDTH-1:0]),
        .word   (curWord)
    );

    assign inReady  = (state == IDLE);
    assign outValid = (state == OUTPUT);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (inValid) stateNext = DECODE;
            DECODE:  if (idx == 3'd7) stateNext = OUTPUT;
            OUTPUT:  if (outReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // dataOut/lenErr are loaded only on the final decode edge, so they stay
    // stable in OUTPUT and keep their value across the next block's decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            tr      <= '0;
            lr      <= '0;
            sum     <= '0;
            idx     <= '0;
            outBuf  <= '0;
            dataOut <= '0;
            lenErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inValid) begin
                    sr  <= dataIn;
                    tr  <= tagIn;
                    lr  <= lenIn;
                    sum <= '0;
                    idx <= '0;
                end
                DECODE: begin
                    sr  <= sr >> {curLen, 3'b000};
                    sum <= sumNext;
                    idx <= idx + 3'd1;
                    if (idx != 3'd7) begin
                        outBuf[idx] <= curWord;
                    end else begin
                        dataOut <= {curWord, outBuf};
                        lenErr  <= (sumNext + LEN_WIDTH'(TAG_BYTES)) != lr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Directed bench for eight_data_decompress_unit with hand-computed vectors.
module tb_eight_data_decompress_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [255:0] dataIn;
    logic [15:0]  tagIn;
    logic [7:0]   lenIn;
    logic         outValid;
    logic         outReady;
    logic [255:0] dataOut;
    logic         lenErr;

    int nVec = 0;
    int nErr = 0;

    eight_data_decompress_unit dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .dataIn   (dataIn),
        .tagIn    (tagIn),
        .lenIn    (lenIn),
        .outValid (outValid),
        .outReady (outReady),
        .dataOut  (dataOut),
        .lenErr   (lenErr)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] ALL_RAW = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                        32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [255:0] MIX_IN  = {200'h0, 56'hDEADBEEF123480};
    localparam logic [255:0] MIX_OUT = {160'h0, 32'hDEADBEEF, 32'h00001234, 32'hFFFFFF80};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a block until the edge that accepts it (bounded).
    task automatic sendBlock(input logic [255:0] d, input logic [15:0] t, input logic [7:0] l);
        int i;
        dataIn = d; tagIn = t; lenIn = l; inValid = 1'b1;
        for (i = 0; i < 20 && !inReady; i++) begin
            @(posedge clk); #1;
        end
        chk("accept_ready", 256'(inReady), 256'(1));
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic waitOut(input string tag);
        for (int i = 0; i < 20 && !outValid; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, 256'(outValid), 256'(1));
    endtask

    task automatic handoff();
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        chk("handoff_outValid", 256'(outValid), 256'(0));
        chk("handoff_inReady", 256'(inReady), 256'(1));
    endtask

    task automatic runBlock(input string tag, input logic [255:0] d, input logic [15:0] t,
                            input logic [7:0] l, input logic [255:0] expD, input logic expE);
        sendBlock(d, t, l);
        waitOut({tag, "_valid"});
        chk({tag, "_data"}, dataOut, expD);
        chk({tag, "_lenErr"}, 256'(lenErr), 256'(expE));
        handoff();
    endtask

    initial begin
        logic [255:0] rnd;
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
        dataIn = '0; tagIn = '0; lenIn = '0;
        #3;
        chk("rst_inReady", 256'(inReady), 256'(1));
        chk("rst_outValid", 256'(outValid), 256'(0));
        chk("rst_dataOut", dataOut, 256'(0));
        chk("rst_lenErr", 256'(lenErr), 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // All raw: exact 8-edge latency after accept.
        sendBlock(ALL_RAW, 16'hFFFF, 8'd34);
        chk("raw_inReady_busy", 256'(inReady), 256'(0));
        repeat (7) @(posedge clk);
        #1;
        chk("raw_lat7", 256'(outValid), 256'(0));
        @(posedge clk); #1;
        chk("raw_lat8", 256'(outValid), 256'(1));
        chk("raw_data", dataOut, ALL_RAW);
        chk("raw_lenErr", 256'(lenErr), 256'(0));
        handoff();
        chk("raw_keep", dataOut, ALL_RAW);

        // All zero tags with random payload.
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        runBlock("zero", rnd, 16'h0000, 8'd2, 256'(0), 1'b0);

        // Mixed tags, correct and wrong length.
        runBlock("mix", MIX_IN, 16'h0039, 8'd9, MIX_OUT, 1'b0);
        runBlock("mixbad", MIX_IN, 16'h0039, 8'd10, MIX_OUT, 1'b1);
        // Out-of-range lengths always flag.
        runBlock("len1", ALL_RAW, 16'hFFFF, 8'd1, ALL_RAW, 1'b1);
        runBlock("len35", ALL_RAW, 16'hFFFF, 8'd35, ALL_RAW, 1'b1);

        // Backpressure with a second block waiting.
        sendBlock(MIX_IN, 16'h0039, 8'd9);
        waitOut("bp_valid");
        dataIn = ALL_RAW; tagIn = 16'hFFFF; lenIn = 8'd34; inValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 256'(outValid), 256'(1));
            chk("bp_hold_data", dataOut, MIX_OUT);
            chk("bp_hold_inReady", 256'(inReady), 256'(0));
        end
        handoff();
        chk("bp_keep", dataOut, MIX_OUT);
        @(posedge clk); #1;
        inValid = 1'b0;
        chk("bp_second_busy", 256'(inReady), 256'(0));
        repeat (7) @(posedge clk);
        #1;
        chk("bp_second_lat7", 256'(outValid), 256'(0));
        @(posedge clk); #1;
        chk("bp_second_valid", 256'(outValid), 256'(1));
        chk("bp_second_data", dataOut, ALL_RAW);
        chk("bp_second_lenErr", 256'(lenErr), 256'(0));
        handoff();

        // Reset during the 4th decode cycle.
        sendBlock(MIX_IN, 16'h0039, 8'd9);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_outValid", 256'(outValid), 256'(0));
        chk("mrst_dataOut", dataOut, 256'(0));
        chk("mrst_inReady", 256'(inReady), 256'(1));
        chk("mrst_lenErr", 256'(lenErr), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        runBlock("post_rst", ALL_RAW, 16'hFFFF, 8'd34, ALL_RAW, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/eight_data_decompress_unit.md
Name: eight_data_decompress_unit

Overview:
- Inverse of the eight-word compression path.
- Accepts one packed block: eight variable-length payloads, eight 2-bit tags and a total byte length.
- Expands the block back into eight full-width words, one word per cycle, using a byte-pointer shift register.
- Sits at the consumer end of the compressed stream, with a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, width of one uncompressed word in bits. Only 32 is supported.
- TAG_WIDTH, 2, tag bits per word.
- LEN_WIDTH, 8, width of the byte-length field.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inValid  input  1  upstream block valid.
- inReady  output  1  block accepted when inValid&inReady at a clk edge.
- dataIn  input  DATA_WIDTH*8  packed payload; word 0 payload in the least-significant bytes, word i+1 packed immediately above word i, unused upper bits ignored.
- tagIn  input  TAG_WIDTH*8  tag of word i at [2i+1:2i].
- lenIn  input  LEN_WIDTH  total block bytes, including 2 tag bytes.
- outValid  output  1  decoded block valid.
- outReady  input  1  downstream accepts.
- dataOut  output  DATA_WIDTH*8  word i at [32i+31:32i].
- lenErr  output  1  recomputed length differs from lenIn; valid with outValid.

Behaviour:
- Tag encoding (decided, shared with the compressor):
  - 00: 0 bytes, word = 0.
  - 01: 1 byte, sign-extended.
  - 10: 2 bytes, sign-extended.
  - 11: 4 bytes, raw.
- Reset (asynchronous): state=IDLE, inReady=1, outValid=0, dataOut=0, lenErr=0, internal pointer, index and byte sum cleared. A reset mid-block discards the partial block silently.
- FSM states are IDLE, DECODE and OUTPUT.
- IDLE:
  - inReady=1.
  - On inValid&inReady, register dataIn into shift register SR, tagIn into TR, lenIn into LR.
  - Clear idx=0 and sum=0, then go to DECODE.
  - inReady is 0 in every other state. Upstream holds inValid/data until accepted.
- DECODE, one word per cycle:
  - n = byteLen(TR[idx]).
  - outBuf[idx] = decode(TR[idx], SR[31:0]).
  - SR >>= 8*n (zero fill).
  - sum += n.
  - idx++.
  - After the edge with idx==7, go to OUTPUT. This is exactly 8 cycles, independent of the tags.
- OUTPUT:
  - outValid=1, dataOut=outBuf, lenErr=(sum+2 != LR).
  - Hold all outputs stable while outReady=0.
  - On outValid&outReady go to IDLE; outValid=0 and inReady=1 from the next cycle.
  - dataOut keeps its last value after the handoff. It is not cleared.
- Latency: accept edge k, then outValid is high after edge k+8. Minimum block period is 10 cycles.
- Widths and limits:
  - sum is LEN_WIDTH bits; maximum legal value is 32.
  - lenIn > 34 or lenIn < 2 always flags lenErr.
  - Data is still decoded from the tags. lenIn never steers the decode.
- Simultaneous events:
  - inValid in DECODE/OUTPUT is ignored.
  - outReady in IDLE/DECODE is ignored.
  - There is no in/out overlap, so no bypass path is needed.

Decomposition:
- Shared package contents:
  - NUM_UNITS=8.
  - Tag constants TAG_ZERO=2'b00, TAG_B1=2'b01, TAG_B2=2'b10, TAG_RAW=2'b11.
  - Function byteLen(tag) returning 0/1/2/4.
  - TAG_BYTES=2.
  - These are shared with the compress-side length mapping.
- One combinational sub-module, word_decoder: inputs tag and 32-bit low window, outputs 32-bit word. It implements zero / sign-extend-8 / sign-extend-16 / pass.
- The FSM, SR, outBuf, counters and compare live in the top module.

Test Plan:
- All tags 11, dataIn = words 0x11111111 through 0x88888888 (word0 lowest), lenIn=34 -> dataOut equals dataIn, lenErr=0, outValid rises 8 edges after accept.
- All tags 00, dataIn=random, lenIn=2 -> dataOut=0, lenErr=0.
- tagIn=16'h0039, dataIn[55:0]=56'hDEADBEEF123480, rest 0, lenIn=9 -> word0=0xFFFFFF80, word1=0x00001234, word2=0xDEADBEEF, words3-7=0, lenErr=0.
- Same block as the previous scenario with lenIn=10 -> identical dataOut, lenErr=1.
- Backpressure: outReady=0 for 5 cycles in OUTPUT, second block presented -> outValid and dataOut stable, inReady=0; outReady=1 -> inReady=1 next cycle, second block accepted and decoded correctly.
- Assert reset during the 4th DECODE cycle -> outValid=0, dataOut=0, inReady=1 immediately; after release, the all-11 block decodes correctly with no residue.
